// File: rtl/regfile_dual_wr.sv
// -----------------------------------------------------------------------------
// regfile_dual_wr
//   Decode-stage register file with two combinational read ports and two
//   write ports for dual-issue writeback. The array has no per-entry reset.
//   Instead, a sweep state machine writes zero to every entry after reset,
//   and ready rises when the sweep is done.
//
// Parameters
//   DATA_W   : register width in bits
//   ADDR_W   : address width, DEPTH = 2**ADDR_W
//   ZERO_REG : 1 -> entry 0 reads as zero and ignores writes
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   we3/wa3/wd3     : write port A (enable, address, data)
//   we4/wa4/wd4     : write port B; on a same-address collision B wins
//   ra1/rd1         : read port 1 (combinational)
//   ra2/rd2         : read port 2 (combinational)
//   ready           : high once the post-reset clear sweep has finished
//   dbg_state       : current FSM state (0 = CLEAR, 1 = RUN), for observation
//
// Optional feature
//   REGFILE_BYPASS_EN : when defined, reads in RUN forward same-cycle write
//                       data (wd4 over wd3 over the array).
// -----------------------------------------------------------------------------
module regfile_dual_wr #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] wa4,
    input  logic [DATA_W-1:0] wd4,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              ready,
    output logic              dbg_state
);

    localparam int DEPTH = 2**ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;

    logic [DATA_W-1:0] rf [DEPTH];

    // Writes to entry 0 are dropped when it is the hardwired zero register.
    logic wr_a_ok, wr_b_ok;
    assign wr_a_ok = we3 && !((ZERO_REG != 0) && (wa3 == '0));
    assign wr_b_ok = we4 && !((ZERO_REG != 0) && (wa4 == '0));

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            ST_CLEAR: begin
                // The counter wraps to 0 on the final sweep edge.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // ---------------------------------------------------------------- Array
    // No reset on the array. While rst is held, state is already CLEAR with
    // cnt 0, so the clear write to entry 0 is harmless. In RUN, port B's
    // assignment comes last, so it wins on a same-address collision.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            rf[cnt_q] <= '0;
        end else begin
            if (wr_a_ok) rf[wa3] <= wd3;
            if (wr_b_ok) rf[wa4] <= wd4;
        end
    end

    // ---------------------------------------------------------------- Reads
    always_comb begin
        rd1 = rf[ra1];
`ifdef REGFILE_BYPASS_EN
        if (we3 && (wa3 == ra1)) rd1 = wd3;
        if (we4 && (wa4 == ra1)) rd1 = wd4;
`endif
        if (state_q == ST_CLEAR)                 rd1 = '0;
        if ((ZERO_REG != 0) && (ra1 == '0))      rd1 = '0;
    end

    always_comb begin
        rd2 = rf[ra2];
`ifdef REGFILE_BYPASS_EN
        if (we3 && (wa3 == ra2)) rd2 = wd3;
        if (we4 && (wa4 == ra2)) rd2 = wd4;
`endif
        if (state_q == ST_CLEAR)                 rd2 = '0;
        if ((ZERO_REG != 0) && (ra2 == '0))      rd2 = '0;
    end

    assign ready     = ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_dual_wr.sv
// -----------------------------------------------------------------------------
// tb_regfile_dual_wr
//   Directed bench for regfile_dual_wr. Two instances share every input:
//   dut_z has ZERO_REG=1 and dut_n has ZERO_REG=0. Expected values are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_regfile_dual_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic        we3, we4;
    logic [4:0]  wa3, wa4, ra1, ra2;
    logic [31:0] wd3, wd4;
    logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;
    logic        ready_z, ready_n, st_z, st_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_dual_wr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z),
        .ready(ready_z), .dbg_state(st_z)
    );

    regfile_dual_wr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst(rst),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .ready(ready_n), .dbg_state(st_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, never at the edge itself.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rst has just been released; expect ready low after edges 1..31 and
    // high after edge 32.
    task automatic sweep_check(input string tag);
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k < 32) check({tag, "_ready_low"}, {31'b0, ready_z}, 32'd0);
            else        check({tag, "_ready_high"}, {31'b0, ready_z}, 32'd1);
        end
        check({tag, "_ready_n"}, {31'b0, ready_n}, 32'd1);
        check({tag, "_state"},   {31'b0, st_z},    32'd1);
    endtask

    task automatic idle_writes();
        we3 = 1'b0; we4 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        we3 = 1'b0; wa3 = '0; wd3 = '0;
        we4 = 1'b0; wa4 = '0; wd4 = '0;
        ra1 = 5'd0; ra2 = 5'd0;

        // ---------------- first reset and sweep
        step(); step();
        check("rst_ready", {31'b0, ready_z}, 32'd0);
        check("rst_state", {31'b0, st_z},    32'd0);
        rst = 1'b0;
        sweep_check("sweep1");

        // ---------------- garbage in entry 7, then reset must clear it
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hDEADBEEF;
        step();
        idle_writes();
        ra1 = 5'd7;
        #1;
        check("garbage_written", rd1_z, 32'hDEADBEEF);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_ready", {31'b0, ready_z}, 32'd0);
        check("clear_reads_zero", rd1_z, 32'd0);
        step();
        rst = 1'b0;
        sweep_check("sweep2");
        check("entry7_cleared_z", rd1_z, 32'd0);
        check("entry7_cleared_n", rd1_n, 32'd0);

        // ---------------- dual write
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'h11111111;
        we4 = 1'b1; wa4 = 5'd9; wd4 = 32'h22222222;
        ra1 = 5'd5; ra2 = 5'd9;
`ifndef REGFILE_BYPASS_EN
        #1;
        check("no_bypass_old_rd1", rd1_z, 32'd0);
        check("no_bypass_old_rd2", rd2_z, 32'd0);
`endif
        step();
        idle_writes();
        #1;
        check("dual_rd1", rd1_z, 32'h11111111);
        check("dual_rd2", rd2_z, 32'h22222222);

        // ---------------- collision: port B wins
        we3 = 1'b1; wa3 = 5'd12; wd3 = 32'hAAAA0000;
        we4 = 1'b1; wa4 = 5'd12; wd4 = 32'h0000BBBB;
        step();
        idle_writes();
        ra1 = 5'd12; ra2 = 5'd5;
        #1;
        check("collision_z",   rd1_z, 32'h0000BBBB);
        check("collision_n",   rd1_n, 32'h0000BBBB);
        check("other_intact",  rd2_z, 32'h11111111);

        // ---------------- zero register
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFFFFFF;
        step();
        idle_writes();
        ra1 = 5'd0; ra2 = 5'd0;
        #1;
        check("zero_reg_rd1", rd1_z, 32'd0);
        check("zero_reg_rd2", rd2_z, 32'd0);
        check("plain_reg0",   rd1_n, 32'hFFFFFFFF);

        // ---------------- bypass / read-after-write timing
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hCAFE0001;
        step();
        idle_writes();
        ra1 = 5'd3; ra2 = 5'd3;
        we4 = 1'b1; wa4 = 5'd3; wd4 = 32'h12345678;
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h55555555;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_rd1", rd1_z, 32'h12345678);
        check("bypass_rd2", rd2_n, 32'h12345678);
`else
        check("nobypass_rd1", rd1_z, 32'hCAFE0001);
        check("nobypass_rd2", rd2_n, 32'hCAFE0001);
`endif
        step();
        idle_writes();
        #1;
        check("raw_next_rd1", rd1_z, 32'h12345678);

        // Bypass to address 0 only reaches a non-hardwired entry 0.
        ra1 = 5'd0;
        we4 = 1'b1; wa4 = 5'd0; wd4 = 32'h0BADF00D;
        #1;
        check("byp0_zero_reg", rd1_z, 32'd0);
`ifdef REGFILE_BYPASS_EN
        check("byp0_plain", rd1_n, 32'h0BADF00D);
`else
        check("byp0_plain", rd1_n, 32'hFFFFFFFF);
`endif
        step();
        idle_writes();
        #1;
        check("reg0_after", rd1_n, 32'h0BADF00D);

        // ---------------- mid-sweep reset, writes during CLEAR dropped
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("midsweep_ready", {31'b0, ready_z}, 32'd0);
        rst = 1'b1;
        #1;
        check("midsweep_rst_state", {31'b0, st_z}, 32'd0);
        step();
        rst = 1'b0;
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h77777777;
        we4 = 1'b1; wa4 = 5'd4; wd4 = 32'h88888888;
        ra1 = 5'd3; ra2 = 5'd4;
        #1;
        check("clear_rd1_zero", rd1_z, 32'd0);
        sweep_check("sweep3");
        idle_writes();
        #1;
        check("dropped_a_z", rd1_z, 32'd0);
        check("dropped_b_z", rd2_z, 32'd0);
        check("dropped_a_n", rd1_n, 32'd0);
        check("dropped_b_n", rd2_n, 32'd0);

        // ready stays high in RUN
        step(); step();
        check("ready_holds", {31'b0, ready_z}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/regfile_dual_wr.md
Name: regfile_dual_wr

Overview:
- Parametrised successor to the single-write CPU register file: two read ports, two write ports for dual-issue writeback, configurable width and depth.
- Array is cleared by a post-reset sweep state machine instead of per-entry reset logic.
- Sits in the decode stage; reads are combinational, writes commit on the rising clock edge.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero; when 0 entry 0 is an ordinary register.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- we3  input  1  write enable, port A.
- wa3  input  ADDR_W  write address, port A.
- wd3  input  DATA_W  write data, port A.
- we4  input  1  write enable, port B.
- wa4  input  ADDR_W  write address, port B.
- wd4  input  DATA_W  write data, port B.
- ra1  input  ADDR_W  read address 1.
- ra2  input  ADDR_W  read address 2.
- rd1  output  DATA_W  read data 1, combinational.
- rd2  output  DATA_W  read data 2, combinational.
- ready  output  1  high once the clear sweep has completed.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- States: CLEAR and RUN.
  - rst asserted (any time, including mid-sweep or mid-operation): state <= CLEAR, sweep counter <= 0, ready <= 0 immediately.
  - Array contents are not reset directly.
- CLEAR:
  - Each rising edge with rst low writes 0 to rf[cnt], then cnt <= cnt + 1.
  - The edge that writes entry DEPTH-1 moves to RUN and sets ready <= 1.
  - Sweep length is exactly DEPTH cycles after rst deasserts; cnt wraps to 0 on exit.
  - During CLEAR, we3/we4 are ignored and rd1/rd2 read 0.
- RUN:
  - A write port commits wd to rf[wa] on the rising edge when its enable is high.
  - Same-address collision (we3 & we4 & wa3 == wa4): port B (wd4) wins.
  - With ZERO_REG=1, writes to address 0 are discarded and any read of address 0 returns 0.
- Reads: rdN = rf[raN], subject to the zero/CLEAR rules above and the bypass rule under Optional Feature.
- ready stays high until the next rst.
- Latency:
  - Without bypass, a write is visible on reads from the cycle after the committing edge.
  - No stalls or backpressure; writes are always accepted in RUN.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined, in RUN only:
  - rdN forwards same-cycle write data when raN matches an enabled write address: wd4 takes priority over wd3, then the array.
  - Address 0 is still 0 when ZERO_REG=1.
  - Read-after-write has zero-cycle latency.
- Not defined: no forwarding; reads see only the array contents (one-cycle visibility).

Test Plan:
- Reset then idle: assert rst, release; check ready=0 for exactly 32 edges, then 1. ra1=7 reads 0 (even after earlier garbage writes at the same address).
- Dual write: in RUN, we3=1 wa3=5 wd3=0x11111111, we4=1 wa4=9 wd4=0x22222222. Next cycle ra1=5 gives 0x11111111 and ra2=9 gives 0x22222222.
- Collision: wa3=wa4=12, wd3=0xAAAA0000, wd4=0x0000BBBB. rf[12] reads 0x0000BBBB.
- Zero register: we3=1 wa3=0 wd3=0xFFFFFFFF. ra1=0 reads 0. Repeat with ZERO_REG=0: reads 0xFFFFFFFF.
- Bypass:
  - With REGFILE_BYPASS_EN, ra1=3, we4=1 wa4=3 wd4=0x12345678 gives rd1=0x12345678 in the same cycle.
  - Without the macro, rd1 shows the old value until the next cycle.
- Mid-sweep reset: assert rst at sweep cycle 10, release. ready=0 for a full 32 further edges, and writes issued during CLEAR are dropped.
